gated_logic_pipe: RTL and testbench
===================================

Name: gated_logic_pipe

Overview:
Parametrised successor to the gate-into-flip-flop cell. Reduces NUM_IN operands of WIDTH bits with a per-transaction selectable bitwise operation (AND/OR/XOR/NAND). Carries each result through a STAGES-deep valid/ready register pipeline with full back-pressure. Sits between any operand producer and a consumer that may stall.

Parameters:
WIDTH, 8, bit width of each operand and of the result (>=1)
NUM_IN, 2, number of operands reduced per transaction (>=2)
STAGES, 2, number of register stages, equal to latency in cycles (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand set and op are valid
in_ready  output  1  pipeline accepts a transaction this cycle
in_data  input  NUM_IN*WIDTH  operands; operand k = in_data[k*WIDTH +: WIDTH]
in_op  input  2  0=AND, 1=OR, 2=XOR, 3=NAND; sampled with in_data
out_valid  output  1  out_data holds a result
out_ready  input  1  consumer takes the result this cycle
out_data  output  WIDTH  reduced result
out_zero  output  1  out_valid and out_data are all zeros

Behaviour:
- Reset (async, rst=1): every stage valid bit = 0, every stage data reg = 0. Outputs: out_valid=0, out_data=0, out_zero=0, in_ready=1 (combinational from out_ready/valids). Reset released mid-traffic: all in-flight results are discarded, none re-emerge.
- Reduction: combinational over the NUM_IN operands at the input. NAND = bitwise NOT of the AND reduction, not a chained NAND. Result is WIDTH bits with no carry or extension.
- Transfer rules:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_op travels with its own transaction. Changing in_op while the pipe holds data does not affect earlier results.
- Stage i holds (valid_i, data_i); stage STAGES-1 drives out_valid/out_data.
  - ready_i = !valid_i || ready_{i+1}, with ready_STAGES = out_ready; in_ready = ready_0. This is a combinational chain, so bubbles are absorbed.
  - On a clock edge where ready_i=1: stage i loads from stage i-1 (or from the input reducer when i=0), copying that source's valid and data.
  - On a clock edge where ready_i=0: stage i holds.
- Latency: a result accepted at edge t appears on out_valid after edge t+STAGES-1 if no stall, i.e. STAGES edges including acceptance. Throughput is 1 per cycle when out_ready=1 continuously.
- Full: all valid and out_ready=0 gives in_ready=0. Data and out_data stay stable while out_valid && !out_ready.
- Empty: out_valid=0; out_data keeps its last value (no clear), but out_zero=0.
- Simultaneous accept and emit on a full pipe is allowed (in_ready=1 because out_ready=1). The pipe stays full with no loss.
- in_valid=0 when accepted loads a bubble (valid 0). Data registers may load don't-care.

Optional Feature:
Macro GATED_LOGIC_PIPE_PARITY_EN.
- Defined: extra output out_parity (1 bit) equal to the XOR of all out_data bits. It is registered alongside the data in every stage, reset 0, and valid only when out_valid.
- Undefined: the port and the parity registers are absent; all other behaviour is identical.

Decomposition:
- Package gated_logic_pkg: 2-bit op typedef with constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3; the reduction function reduce_op(operands, op).
- Sub-module gated_logic_stage: one valid/data register stage with ready_in/ready_out, instantiated STAGES times by a generate loop.
- The top level holds the reducer, ready chain, out_zero and the optional parity path.

Test Plan:
- Reset: rst=1 mid-stream with 2 results in flight, release, out_ready=1 -> out_valid=0, out_data=0 for 3 cycles, no stale result emitted.
- Op coverage: WIDTH=8, NUM_IN=2, operands 0xF0/0x3C, ops 0..3 back-to-back with out_ready=1 -> outputs 0x30, 0xFC, 0xCC, 0xCF in order, first appearing STAGES cycles after acceptance.
- Zero flag: AND of 0xAA and 0x55 -> out_data=0x00 with out_zero=1; the next result 0xFF has out_zero=0.
- Back-pressure: out_ready=0, stream 5 transactions with STAGES=2 -> only 2 accepted, in_ready=0 thereafter; release out_ready -> all 5 emerge in order with no duplicates.
- Full-pipe pass-through: pipe full, out_ready=1 and in_valid=1 every cycle for 10 cycles -> 10 accepts, 10 emits, in_ready stays 1.
- Parity (macro defined): result 0x07 -> out_parity=1; result 0x0F -> out_parity=0.

Source files
------------

// File: rtl/gated_logic_pkg.sv
// Shared op encoding and per-bit reduction helper for the gated logic pipe.
package gated_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    // Upper bound on operands per transaction supported by reduce_op.
    localparam int unsigned MAX_IN = 64;

    // Reduces one bit column (bit k = operand k) over the low num_in entries.
    function automatic logic reduce_op(input logic [MAX_IN-1:0] operands,
                                       input int unsigned       num_in,
                                       input op_e               op);
        logic [MAX_IN-1:0] mask;
        logic              all_ones;
        logic              any_one;
        logic              odd;
        logic              result;
        mask     = ~({MAX_IN{1'b1}} << num_in);
        all_ones = &(operands | ~mask);
        any_one  = |(operands & mask);
        odd      = ^(operands & mask);
        result   = 1'b0;
        unique case (op)
            OP_AND:  result = all_ones;
            OP_OR:   result = any_one;
            OP_XOR:  result = odd;
            OP_NAND: result = ~all_ones;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/gated_logic_stage.sv
// One valid/data register slice; holds while downstream is stalled and it is occupied.
module gated_logic_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign ready_out = !valid_q || ready_in;
    assign valid_out = valid_q;
    assign data_out  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ready_out) begin
            valid_q <= valid_in;
            // Bubbles leave the data register untouched so an empty output keeps its last value.
            if (valid_in) begin
                data_q <= data_in;
            end
        end
    end

endmodule

// File: rtl/gated_logic_pipe.sv
// Bitwise AND/OR/XOR/NAND reduction of NUM_IN operands into a STAGES-deep valid/ready pipe.
// Define GATED_LOGIC_PIPE_PARITY_EN to add the registered out_parity output.
module gated_logic_pipe
    import gated_logic_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero
`ifdef GATED_LOGIC_PIPE_PARITY_EN
    ,
    output logic                    out_parity
`endif
);

`ifdef GATED_LOGIC_PIPE_PARITY_EN
    localparam int unsigned DATA_W = WIDTH + 1;
`else
    localparam int unsigned DATA_W = WIDTH;
`endif

    logic [WIDTH-1:0]  reduced;
    logic [DATA_W-1:0] stage_in;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [MAX_IN-1:0] column;
        for (genvar k = 0; k < NUM_IN; k++) begin : g_op
            assign column[k] = in_data[k*WIDTH+b];
        end
        if (NUM_IN < MAX_IN) begin : g_pad
            assign column[MAX_IN-1:NUM_IN] = '0;
        end
        assign reduced[b] = reduce_op(column, NUM_IN, op_e'(in_op));
    end

`ifdef GATED_LOGIC_PIPE_PARITY_EN
    assign stage_in = {^reduced, reduced};
`else
    assign stage_in = reduced;
`endif

    logic [STAGES:0]   valid_c;
    logic [STAGES:0]   ready_c;
    logic [DATA_W-1:0] data_c [STAGES+1];

    assign valid_c[0]      = in_valid;
    assign data_c[0]       = stage_in;
    assign ready_c[STAGES] = out_ready;
    assign in_ready        = ready_c[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        gated_logic_stage #(
            .WIDTH(DATA_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .valid_in (valid_c[i]),
            .data_in  (data_c[i]),
            .ready_in (ready_c[i+1]),
            .ready_out(ready_c[i]),
            .valid_out(valid_c[i+1]),
            .data_out (data_c[i+1])
        );
    end

    assign out_valid = valid_c[STAGES];
    assign out_data  = data_c[STAGES][WIDTH-1:0];
    assign out_zero  = out_valid && (out_data == '0);

`ifdef GATED_LOGIC_PIPE_PARITY_EN
    assign out_parity = data_c[STAGES][WIDTH];
`endif

endmodule

// File: tb/tb_gated_logic_pipe.sv
// Self-checking bench for gated_logic_pipe: vector table plus scoreboard and corner-case sequences.
module tb_gated_logic_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NUM_IN = 2;
    localparam int unsigned STAGES = 2;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [1:0]              in_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_zero;
`ifdef GATED_LOGIC_PIPE_PARITY_EN
    logic                    out_parity;
`endif

    gated_logic_pipe #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_zero (out_zero)
`ifdef GATED_LOGIC_PIPE_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp;
        logic       zero;
    } vec_t;

    vec_t tab [8];
    exp_t exp_q [$];
    exp_t cur_exp;
    int   checks;
    int   errors;
    int   emitted;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endfunction

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [1:0] op);
        logic [7:0] r;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = ~(a & b);
        endcase
        return {r, (r == 8'h00)};
    endfunction

    // Scoreboard: push on accept, pop and compare on emit.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_emit: got 0x%0h expected no output", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_zero", out_zero, e.zero);
`ifdef GATED_LOGIC_PIPE_PARITY_EN
                    check("out_parity", out_parity, ^e.data);
`endif
                    emitted++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input exp_t e);
        in_data  = {b, a};
        in_op    = op;
        cur_exp  = e;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input exp_t e, input bit rnd);
        bit acc;
        acc = 1'b0;
        set_in(a, b, op, e);
        for (int c = 0; c < 100 && !acc; c++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected accept within 100 cycles");
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", out_valid, 1'b0);
    endtask

    function automatic logic [7:0] bp_val(input int i);
        return 8'(i * 16 + 3);
    endfunction

    initial begin
        int idx;
        int acc_cnt;
        int base;
        bit acc;

        tab[0] = '{8'hF0, 8'h3C, 2'd0, 8'h30, 1'b0};
        tab[1] = '{8'hF0, 8'h3C, 2'd1, 8'hFC, 1'b0};
        tab[2] = '{8'hF0, 8'h3C, 2'd2, 8'hCC, 1'b0};
        tab[3] = '{8'hF0, 8'h3C, 2'd3, 8'hCF, 1'b0};
        tab[4] = '{8'hAA, 8'h55, 2'd0, 8'h00, 1'b1};
        tab[5] = '{8'hFF, 8'hFF, 2'd0, 8'hFF, 1'b0};
        tab[6] = '{8'h07, 8'h00, 2'd2, 8'h07, 1'b0};
        tab[7] = '{8'h0F, 8'h0F, 2'd1, 8'h0F, 1'b0};

        checks    = 0;
        errors    = 0;
        emitted   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 2'd0;
        out_ready = 1'b1;
        cur_exp   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_out_zero", out_zero, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency: accepted at edge t, visible after edge t+STAGES-1.
        set_in(8'hF0, 8'h3C, 2'd0, {8'h30, 1'b0});
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("lat_edge_t_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_edge_t1_valid", out_valid, 1'b1);
        check("lat_edge_t1_data", out_data, 8'h30);
        drain();

        for (int i = 0; i < 8; i++) begin
            send(tab[i].a, tab[i].b, tab[i].op, {tab[i].exp, tab[i].zero}, 1'b0);
        end
        drain();

        // Back-pressure: only STAGES transactions fit while the consumer stalls.
        base      = emitted;
        out_ready = 1'b0;
        idx       = 0;
        for (int c = 0; c < 5; c++) begin
            set_in(bp_val(idx), 8'h00, 2'd2, {bp_val(idx), 1'b0});
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        check("bp_accepted", idx, 2);
        @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_stall_valid", out_valid, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, bp_val(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        while (idx < 5) begin
            send(bp_val(idx), 8'h00, 2'd2, {bp_val(idx), 1'b0}, 1'b0);
            idx++;
        end
        drain();
        check("bp_emitted", emitted - base, 5);

        // Full pipe with simultaneous accept and emit every cycle.
        out_ready = 1'b0;
        send(8'h11, 8'h00, 2'd1, {8'h11, 1'b0}, 1'b0);
        send(8'h22, 8'h00, 2'd1, {8'h22, 1'b0}, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        base    = emitted;
        acc_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            set_in(8'(8'h40 + c), 8'hFF, 2'd0, {8'(8'h40 + c), 1'b0});
            @(negedge clk);
            check("pt_in_ready", in_ready, 1'b1);
            if (in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        check("pt_accepts", acc_cnt, 10);
        check("pt_emits", emitted - base, 10);
        drain();

        for (int n = 0; n < 30; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic [1:0] op;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 2'($urandom_range(0, 3));
            send(a, b, op, model(a, b, op), 1'b1);
        end
        drain();

        // Reset mid-stream with two results in flight.
        out_ready = 1'b0;
        send(8'h5A, 8'hFF, 2'd0, {8'h5A, 1'b0}, 1'b0);
        send(8'hA5, 8'hFF, 2'd0, {8'hA5, 1'b0}, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid_valid", out_valid, 1'b0);
            check("rst_mid_data", out_data, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
